// File: rtl/ddi_conflict_monitor.sv
// Independent safety monitor on the DDI light_state bus: flags unsafe head
// sequences, latches the first cause and holds maintenance until cleared.
module ddi_conflict_monitor #(
  parameter int MIN_YELLOW = 3,
  parameter int ALL_RED    = 2,
  parameter int MAX_STUCK  = 50000,
  parameter int CNT_W      = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] light_state,
  input  logic       fault_clr,
  output logic       maintenance,
  output logic [2:0] fault_code,
  output logic [3:0] fault_state
);

  typedef enum logic {MONITOR = 1'b0, FAULT = 1'b1} state_t;

  localparam logic [1:0] RED    = 2'b00;
  localparam logic [1:0] GREEN  = 2'b01;
  localparam logic [1:0] YELLOW = 2'b10;
  localparam logic [1:0] BAD    = 2'b11;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] MIN_Y   = CNT_W'(MIN_YELLOW);
  localparam logic [CNT_W-1:0] ALL_R   = CNT_W'(ALL_RED);
  localparam logic [CNT_W-1:0] WD_LIM  = CNT_W'(MAX_STUCK - 1);

  state_t           state_q, state_d;
  logic             maint_q, maint_d;
  logic [2:0]       code_q, code_d;
  logic [3:0]       fstate_q, fstate_d;
  logic [3:0]       prev_q, prev_d;
  logic [CNT_W-1:0] yel_a_q, yel_a_d, yel_b_q, yel_b_d;
  logic [CNT_W-1:0] allred_q, allred_d;
  logic [CNT_W-1:0] stuck_q, stuck_d;

  logic [1:0]       ha, hb, pa, pb;
  logic             chk_conflict, chk_invalid, chk_step, chk_short, chk_clear, chk_wdog;
  logic [2:0]       chk_code;
  logic [CNT_W-1:0] stuck_inc;

  function automatic logic step_ok(input logic [1:0] p, input logic [1:0] c);
    step_ok = (p == c) || (p == RED && c == GREEN) ||
              (p == GREEN && c == YELLOW) || (p == YELLOW && c == RED);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    sat_inc = (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  always_comb begin
    ha = light_state[1:0];
    hb = light_state[3:2];
    pa = prev_q[1:0];
    pb = prev_q[3:2];

    chk_conflict = (ha != RED) && (hb != RED);
    chk_invalid  = (ha == BAD) || (hb == BAD);
    chk_step     = !step_ok(pa, ha) || !step_ok(pb, hb);
    chk_short    = (pa == YELLOW && ha == RED && yel_a_q < MIN_Y) ||
                   (pb == YELLOW && hb == RED && yel_b_q < MIN_Y);
    chk_clear    = (pa == RED && ha == GREEN && allred_q < ALL_R) ||
                   (pb == RED && hb == GREEN && allred_q < ALL_R);
    // Watchdog looks at the count this cycle would produce, so a hold of
    // MAX_STUCK cycles trips on the edge ending the last of them.
    stuck_inc    = sat_inc(stuck_q);
    chk_wdog     = (light_state == prev_q) && (stuck_inc >= WD_LIM);

    if (chk_conflict)     chk_code = 3'b001;
    else if (chk_invalid) chk_code = 3'b010;
    else if (chk_step)    chk_code = 3'b011;
    else if (chk_short)   chk_code = 3'b100;
    else if (chk_clear)   chk_code = 3'b101;
    else if (chk_wdog)    chk_code = 3'b110;
    else                  chk_code = 3'b000;
  end

  always_comb begin
    state_d  = state_q;
    maint_d  = maint_q;
    code_d   = code_q;
    fstate_d = fstate_q;
    prev_d   = prev_q;
    yel_a_d  = yel_a_q;
    yel_b_d  = yel_b_q;
    allred_d = allred_q;
    stuck_d  = stuck_q;

    unique case (state_q)
      MONITOR: begin
        if (chk_code != 3'b000) begin
          state_d  = FAULT;
          maint_d  = 1'b1;
          code_d   = chk_code;
          fstate_d = light_state;
        end else begin
          yel_a_d  = (ha == YELLOW) ? sat_inc(yel_a_q) : '0;
          yel_b_d  = (hb == YELLOW) ? sat_inc(yel_b_q) : '0;
          allred_d = (light_state == 4'b0000) ? sat_inc(allred_q) : '0;
          stuck_d  = (light_state == prev_q) ? stuck_inc : '0;
          prev_d   = light_state;
        end
      end
      FAULT: begin
        // Leave only when the intersection is already all-red.
        if (fault_clr && light_state == 4'b0000) begin
          state_d  = MONITOR;
          maint_d  = 1'b0;
          code_d   = 3'b000;
          fstate_d = 4'b0000;
          prev_d   = 4'b0000;
          yel_a_d  = '0;
          yel_b_d  = '0;
          allred_d = ALL_R;
          stuck_d  = '0;
        end
      end
      default: state_d = MONITOR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= MONITOR;
      maint_q  <= 1'b0;
      code_q   <= 3'b000;
      fstate_q <= 4'b0000;
      prev_q   <= 4'b0000;
      yel_a_q  <= '0;
      yel_b_q  <= '0;
      allred_q <= ALL_R;
      stuck_q  <= '0;
    end else begin
      state_q  <= state_d;
      maint_q  <= maint_d;
      code_q   <= code_d;
      fstate_q <= fstate_d;
      prev_q   <= prev_d;
      yel_a_q  <= yel_a_d;
      yel_b_q  <= yel_b_d;
      allred_q <= allred_d;
      stuck_q  <= stuck_d;
    end
  end

  assign maintenance = maint_q;
  assign fault_code  = code_q;
  assign fault_state = fstate_q;

endmodule

// File: tb/tb_ddi_conflict_monitor.sv
// Bench for ddi_conflict_monitor: vector table plus hand sequences for the
// watchdog and fault-clear corner cases, checked through an expected queue.
module tb_ddi_conflict_monitor;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] light_state = 4'b0000;
  logic       fault_clr = 1'b0;
  logic       maintenance;
  logic [2:0] fault_code;
  logic [3:0] fault_state;

  ddi_conflict_monitor #(
    .MIN_YELLOW(3), .ALL_RED(2), .MAX_STUCK(20), .CNT_W(16)
  ) dut (
    .clk(clk), .rst(rst), .light_state(light_state), .fault_clr(fault_clr),
    .maintenance(maintenance), .fault_code(fault_code), .fault_state(fault_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] ls;
    logic       clr;
    logic [7:0] exp;  // {maintenance, fault_code, fault_state}
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] exp_q[$];
  int         checks = 0;
  int         errors = 0;

  task automatic add(input logic r, input logic [3:0] ls, input logic c,
                     input logic m, input logic [2:0] code, input logic [3:0] fs,
                     input int n);
    vec_t v;
    v.rst = r; v.ls = ls; v.clr = c; v.exp = {m, code, fs};
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  // Drive one cycle, push the outputs expected after its closing edge,
  // then pop and compare #1 after that edge.
  task automatic apply(input logic r, input logic [3:0] ls, input logic c,
                       input logic [7:0] exp, input string tag, input int idx);
    logic [7:0] got, want;
    rst = r; light_state = ls; fault_clr = c;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    got  = {maintenance, fault_code, fault_state};
    want = exp_q.pop_front();
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s[%0d] ls=%04b clr=%0b: got m=%0b code=%03b state=%04b, expected m=%0b code=%03b state=%04b",
               tag, idx, ls, c, got[7], got[6:4], got[3:0], want[7], want[6:4], want[3:0]);
    end
  endtask

  initial begin
    int n_ign;
    logic [3:0] rnd_ls;

    // reset state
    add(0, 4'b0000, 0, 0, 3'b000, 4'b0000, 2);
    // legal cycle: nothing fires
    add(1, 4'b0000, 0, 0, 3'b000, 4'b0000, 2);
    add(1, 4'b0001, 0, 0, 3'b000, 4'b0000, 5);
    add(1, 4'b0010, 0, 0, 3'b000, 4'b0000, 3);
    add(1, 4'b0000, 0, 0, 3'b000, 4'b0000, 2);
    add(1, 4'b0100, 0, 0, 3'b000, 4'b0000, 1);
    add(1, 4'b1000, 0, 0, 3'b000, 4'b0000, 3);
    add(1, 4'b0000, 0, 0, 3'b000, 4'b0000, 2);
    add(1, 4'b0001, 0, 0, 3'b000, 4'b0000, 1);
    // conflict, frozen, clr ignored while not all-red, then cleared
    add(1, 4'b0101, 0, 1, 3'b001, 4'b0101, 1);
    add(1, 4'b0000, 0, 1, 3'b001, 4'b0101, 1);
    add(1, 4'b0001, 1, 1, 3'b001, 4'b0101, 1);
    add(1, 4'b0000, 1, 0, 3'b000, 4'b0000, 1);
    // G->R illegal step
    add(1, 4'b0001, 0, 0, 3'b000, 4'b0000, 1);
    add(1, 4'b0000, 0, 1, 3'b011, 4'b0000, 1);
    add(1, 4'b0000, 1, 0, 3'b000, 4'b0000, 1);
    // short yellow
    add(1, 4'b0001, 0, 0, 3'b000, 4'b0000, 1);
    add(1, 4'b0010, 0, 0, 3'b000, 4'b0000, 2);
    add(1, 4'b0000, 0, 1, 3'b100, 4'b0000, 1);
    add(1, 4'b0000, 1, 0, 3'b000, 4'b0000, 1);
    // full yellow, one all-red cycle, then B green: clearance
    add(1, 4'b0001, 0, 0, 3'b000, 4'b0000, 1);
    add(1, 4'b0010, 0, 0, 3'b000, 4'b0000, 3);
    add(1, 4'b0000, 0, 0, 3'b000, 4'b0000, 1);
    add(1, 4'b0100, 0, 1, 3'b101, 4'b0100, 1);
    add(1, 4'b0000, 1, 0, 3'b000, 4'b0000, 1);
    // clr in MONITOR does nothing; invalid head; conflict beats invalid; R->Y
    add(1, 4'b0000, 1, 0, 3'b000, 4'b0000, 1);
    add(1, 4'b0011, 0, 1, 3'b010, 4'b0011, 1);
    add(1, 4'b0000, 1, 0, 3'b000, 4'b0000, 1);
    add(1, 4'b0111, 0, 1, 3'b001, 4'b0111, 1);
    add(1, 4'b0000, 1, 0, 3'b000, 4'b0000, 1);
    add(1, 4'b0010, 0, 1, 3'b011, 4'b0010, 1);
    add(1, 4'b0000, 1, 0, 3'b000, 4'b0000, 1);
    // reset beats fault_clr mid-FAULT
    add(1, 4'b0101, 0, 1, 3'b001, 4'b0101, 1);
    add(0, 4'b0000, 1, 0, 3'b000, 4'b0000, 1);
    add(1, 4'b0000, 0, 0, 3'b000, 4'b0000, 1);

    for (int i = 0; i < vecs.size(); i++)
      apply(vecs[i].rst, vecs[i].ls, vecs[i].clr, vecs[i].exp, "vec", i);

    // watchdog: 19-cycle hold is fine, 20-cycle hold trips on its last edge
    for (int i = 0; i < 19; i++) apply(1, 4'b0001, 0, 8'h00, "hold19", i);
    for (int i = 0; i < 3; i++)  apply(1, 4'b0010, 0, 8'h00, "hold19_yel", i);
    for (int i = 0; i < 2; i++)  apply(1, 4'b0000, 0, 8'h00, "hold19_red", i);
    for (int i = 0; i < 19; i++) apply(1, 4'b0001, 0, 8'h00, "hold20", i);
    apply(1, 4'b0001, 0, {1'b1, 3'b110, 4'b0001}, "wdog", 0);

    // clr with random non-all-red states is ignored, code held
    n_ign = $urandom_range(1, 4);
    for (int i = 0; i < n_ign; i++) begin
      rnd_ls = 4'($urandom_range(1, 15));
      apply(1, rnd_ls, 1, {1'b1, 3'b110, 4'b0001}, "clr_ignored", i);
    end
    apply(1, 4'b0001, 1, {1'b1, 3'b110, 4'b0001}, "clr_0001", 0);
    apply(0, 4'b0001, 0, 8'h00, "rst_fault", 0);
    apply(1, 4'b0000, 0, 8'h00, "post_rst", 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
